// File: rtl/request_distributor_pkg.sv
// rtl/request_distributor_pkg.sv - shared sizing helpers and queue operation encoding
package request_distributor_pkg;

    // Per-cycle queue operation, encoded as {push, pop}
    typedef enum logic [1:0] {
        QOP_IDLE = 2'b00,
        QOP_POP  = 2'b01,
        QOP_PUSH = 2'b10,
        QOP_BOTH = 2'b11
    } queue_op_e;

    // Pointer width for a queue of the given depth; never narrower than one bit
    function automatic int queue_ptr_width(input int queue_size);
        return (queue_size > 1) ? $clog2(queue_size) : 1;
    endfunction

    // Low bit index of port slice port_idx in a flattened bus of slice_width-wide slices
    function automatic int slice_lo(input int port_idx, input int slice_width);
        return port_idx * slice_width;
    endfunction

endpackage

// File: rtl/distributor_output_queue.sv
// rtl/distributor_output_queue.sv - single-port FIFO feeding one consumer, zero head when empty
module distributor_output_queue
    import request_distributor_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int QUEUE_SIZE = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  push_in,
    input  logic                  pop_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] head_out,
    output logic                  valid_out,
    output logic                  full_out
);

    localparam int PTR_W = queue_ptr_width(QUEUE_SIZE);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(QUEUE_SIZE);

    logic [DATA_WIDTH-1:0] mem [QUEUE_SIZE];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        occupancy;
    logic                  do_push;
    logic                  do_pop;
    queue_op_e             op;

    assign valid_out = (occupancy != '0);
    assign full_out  = (occupancy == OCC_FULL);
    assign head_out  = valid_out ? mem[rd_ptr] : '0;

    // Guard against overflow and underflow; fullness comes from registered occupancy only
    always_comb begin
        do_push = push_in & ~full_out;
        do_pop  = pop_in & valid_out;
        op      = queue_op_e'({do_push, do_pop});
    end

    // Pointer and occupancy bookkeeping; push+pop keeps occupancy while both pointers advance
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            case (op)
                QOP_PUSH: begin
                    wr_ptr    <= wr_ptr + PTR_ONE;
                    occupancy <= occupancy + OCC_ONE;
                end
                QOP_POP: begin
                    rd_ptr    <= rd_ptr + PTR_ONE;
                    occupancy <= occupancy - OCC_ONE;
                end
                QOP_BOTH: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    // Storage write; stale contents are harmless because the head reads zero when empty
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/request_distributor.sv
// rtl/request_distributor.sv - routes one request stream to multicast-selected per-port queues
module request_distributor
    import request_distributor_pkg::*;
#(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST                  = 3,
    parameter int OUTPUT_QUEUE_SIZE            = 2,
    parameter int DROP_COUNT_WIDTH             = 16
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_in,
    input  logic [NUM_REQUEST-1:0]                              request_dest_flatted_in,
    input  logic                                                request_valid_in,
    output logic                                                issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_out,
    output logic [NUM_REQUEST-1:0]                              request_valid_flatted_out,
    input  logic [NUM_REQUEST-1:0]                              issue_ack_flatted_in,
    output logic [NUM_REQUEST-1:0]                              queue_full_flatted_out,
    output logic [DROP_COUNT_WIDTH-1:0]                         drop_count_out
);

    localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_ONE = DROP_COUNT_WIDTH'(1);

    logic [NUM_REQUEST-1:0] full_vec;
    logic [NUM_REQUEST-1:0] push_vec;
    logic                   blocked;
    logic                   accept;
    logic                   drop_event;

    // All-or-nothing acceptance: any full targeted queue blocks the whole multicast
    always_comb begin
        blocked    = |(request_dest_flatted_in & full_vec);
        accept     = request_valid_in & ~reset_in & ~blocked;
        push_vec   = accept ? request_dest_flatted_in : '0;
        drop_event = accept & (request_dest_flatted_in == '0);
    end

    assign issue_ack_out          = accept;
    assign queue_full_flatted_out = full_vec;

    for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_port
        distributor_output_queue #(
            .DATA_WIDTH (W),
            .QUEUE_SIZE (OUTPUT_QUEUE_SIZE)
        ) u_queue (
            .clk_in    (clk_in),
            .reset_in  (reset_in),
            .push_in   (push_vec[i]),
            .pop_in    (issue_ack_flatted_in[i]),
            .data_in   (request_in),
            .head_out  (request_flatted_out[slice_lo(i, W) +: W]),
            .valid_out (request_valid_flatted_out[i]),
            .full_out  (full_vec[i])
        );
    end

    // Saturating count of requests accepted with an empty destination mask
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            drop_count_out <= '0;
        end else if (drop_event && (drop_count_out != '1)) begin
            drop_count_out <= drop_count_out + DROP_ONE;
        end
    end

endmodule

// File: tb/tb_request_distributor.sv
// tb/tb_request_distributor.sv - scoreboard bench for request_distributor
module tb_request_distributor;

    localparam int W  = 64;
    localparam int N  = 3;
    localparam int QS = 2;
    localparam int DW = 16;

    logic             clk_in = 1'b0;
    logic             reset_in;
    logic [W-1:0]     request_in;
    logic [N-1:0]     request_dest_flatted_in;
    logic             request_valid_in;
    logic             issue_ack_out;
    logic [W*N-1:0]   request_flatted_out;
    logic [N-1:0]     request_valid_flatted_out;
    logic [N-1:0]     issue_ack_flatted_in;
    logic [N-1:0]     queue_full_flatted_out;
    logic [DW-1:0]    drop_count_out;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] exp_q [N][$];

    always #5 clk_in = ~clk_in;

    request_distributor #(
        .SINGLE_REQUEST_WIDTH_IN_BITS (W),
        .NUM_REQUEST                  (N),
        .OUTPUT_QUEUE_SIZE            (QS),
        .DROP_COUNT_WIDTH             (DW)
    ) dut (
        .clk_in                    (clk_in),
        .reset_in                  (reset_in),
        .request_in                (request_in),
        .request_dest_flatted_in   (request_dest_flatted_in),
        .request_valid_in          (request_valid_in),
        .issue_ack_out             (issue_ack_out),
        .request_flatted_out       (request_flatted_out),
        .request_valid_flatted_out (request_valid_flatted_out),
        .issue_ack_flatted_in      (issue_ack_flatted_in),
        .queue_full_flatted_out    (queue_full_flatted_out),
        .drop_count_out            (drop_count_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Output monitor: every consumer transfer is compared against the scoreboard
    always @(negedge clk_in) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] d;
                d = request_flatted_out[i*W +: W];
                if (request_valid_flatted_out[i] && issue_ack_flatted_in[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out port%0d: got 0x%0h expected nothing", i, d);
                    end else begin
                        check($sformatf("out_port%0d", i), d, exp_q[i].pop_front());
                    end
                end else if (!request_valid_flatted_out[i]) begin
                    check($sformatf("empty_zero_port%0d", i), d, 64'h0);
                end
            end
        end
    end

    // Present a request until acked (bounded); record expected outputs on acceptance
    task automatic send(input logic [W-1:0] d, input logic [N-1:0] dest, input int max_wait,
                        output int waited, output logic [N-1:0] v_at, output logic [N-1:0] f_at);
        request_in              = d;
        request_dest_flatted_in = dest;
        request_valid_in        = 1'b1;
        waited = 0;
        v_at   = '0;
        f_at   = '0;
        forever begin
            @(negedge clk_in);
            if (issue_ack_out) begin
                v_at = request_valid_flatted_out;
                f_at = queue_full_flatted_out;
                for (int i = 0; i < N; i++) if (dest[i]) exp_q[i].push_back(d);
                break;
            end
            if (waited >= max_wait) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no ack for 0x%0h expected ack within %0d cycles", d, max_wait);
                break;
            end
            waited++;
            step();
        end
        step();
        request_valid_in = 1'b0;
    endtask

    initial begin
        int w;
        logic [N-1:0] v, f;

        reset_in                = 1'b1;
        request_in              = '0;
        request_dest_flatted_in = '0;
        request_valid_in        = 1'b1;
        issue_ack_flatted_in    = '1;
        step();
        step();
        @(negedge clk_in);
        check("reset_ack", issue_ack_out, 0);
        check("reset_valid", request_valid_flatted_out, 0);
        check("reset_full", queue_full_flatted_out, 0);
        check("reset_drop", drop_count_out, 0);
        check("reset_data", request_flatted_out == '0, 1);
        step();
        reset_in         = 1'b0;
        request_valid_in = 1'b0;
        mon_en           = 1'b1;

        // Unicast
        send(64'hA, 3'b010, 5, w, v, f);
        check("unicast_ack_wait", w, 0);
        @(negedge clk_in);
        check("unicast_valid", request_valid_flatted_out, 3'b010);
        check("unicast_data", request_flatted_out[1*W +: W], 64'hA);
        step();
        step();

        // Backpressure on port 0
        issue_ack_flatted_in = 3'b110;
        send(64'h1, 3'b001, 5, w, v, f);
        check("bp_first_wait", w, 0);
        send(64'h2, 3'b001, 5, w, v, f);
        check("bp_second_wait", w, 0);
        request_in              = 64'h3;
        request_dest_flatted_in = 3'b001;
        request_valid_in        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check("bp_hold_ack", issue_ack_out, 0);
            check("bp_full", queue_full_flatted_out[0], 1);
            step();
        end
        issue_ack_flatted_in = 3'b111;
        send(64'h3, 3'b001, 5, w, v, f);
        check("bp_third_wait", w, 1);
        repeat (3) step();
        @(negedge clk_in);
        check("bp_drained", request_valid_flatted_out[0], 0);
        step();

        // Multicast blocked by a full port 2
        issue_ack_flatted_in = 3'b011;
        send(64'h20, 3'b100, 5, w, v, f);
        send(64'h21, 3'b100, 5, w, v, f);
        request_in              = 64'hB;
        request_dest_flatted_in = 3'b111;
        request_valid_in        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check("mc_hold_ack", issue_ack_out, 0);
            check("mc_no_partial", request_valid_flatted_out[1:0], 0);
            step();
        end
        issue_ack_flatted_in = 3'b111;
        send(64'hB, 3'b111, 5, w, v, f);
        check("mc_wait", w, 1);
        @(negedge clk_in);
        check("mc_valid", request_valid_flatted_out, 3'b111);
        for (int i = 0; i < N; i++) check($sformatf("mc_data_port%0d", i), request_flatted_out[i*W +: W], 64'hB);
        repeat (3) step();

        // Stream through port 0 with pop every cycle
        send(64'h10, 3'b001, 5, w, v, f);
        check("stream_first_wait", w, 0);
        for (int k = 1; k < 4; k++) begin
            send(64'h10 + 64'(k), 3'b001, 5, w, v, f);
            check("stream_wait", w, 0);
            check("stream_occ_valid", v[0], 1);
            check("stream_occ_not_full", f[0], 0);
        end
        repeat (3) step();

        // Drop counter
        for (int k = 0; k < 5; k++) begin
            send(64'h70 + 64'(k), 3'b000, 5, w, v, f);
            check("drop_wait", w, 0);
        end
        @(negedge clk_in);
        check("drop_count5", drop_count_out, 5);
        check("drop_no_valid", request_valid_flatted_out, 0);
        step();
        request_dest_flatted_in = '0;
        request_valid_in        = 1'b1;
        repeat (65540) @(posedge clk_in);
        #1;
        request_valid_in = 1'b0;
        @(negedge clk_in);
        check("drop_saturate", drop_count_out, 16'hFFFF);
        for (int i = 0; i < N; i++) check($sformatf("drained_port%0d", i), exp_q[i].size(), 0);
        step();

        // Mid-operation reset
        issue_ack_flatted_in = 3'b000;
        send(64'h30, 3'b111, 5, w, v, f);
        send(64'h31, 3'b111, 5, w, v, f);
        @(negedge clk_in);
        check("pre_reset_full", queue_full_flatted_out, 3'b111);
        step();
        reset_in                = 1'b1;
        request_in              = 64'h99;
        request_dest_flatted_in = 3'b000;
        request_valid_in        = 1'b1;
        @(negedge clk_in);
        check("midreset_ack", issue_ack_out, 0);
        step();
        reset_in         = 1'b0;
        request_valid_in = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        @(negedge clk_in);
        check("midreset_valid", request_valid_flatted_out, 0);
        check("midreset_full", queue_full_flatted_out, 0);
        check("midreset_drop", drop_count_out, 0);
        check("midreset_data", request_flatted_out == '0, 1);
        step();

        issue_ack_flatted_in = 3'b111;
        send(64'h55, 3'b001, 5, w, v, f);
        check("post_reset_wait", w, 0);
        repeat (3) step();
        for (int i = 0; i < N; i++) check($sformatf("final_drain_port%0d", i), exp_q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/request_distributor.md
Name: request_distributor

Overview:
- Inverse of the N-to-1 request arbiter: takes one request stream and routes each request to one or more of NUM_REQUEST consumer ports, selected by a one-hot/multi-hot destination mask.
- Each consumer port has its own FIFO so a slow consumer does not stall the others until its queue fills.
- Sits between a shared response/request producer (e.g. a memory-side return path) and per-requester consumers.

Parameters:
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width of one request.
- NUM_REQUEST, 3, number of consumer ports.
- OUTPUT_QUEUE_SIZE, 2, entries per output queue; must be a power of 2, >= 2.
- DROP_COUNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk_in  input  1  clock; all logic rising-edge.
- reset_in  input  1  synchronous, active-high reset.
- request_in  input  SINGLE_REQUEST_WIDTH_IN_BITS  incoming payload.
- request_dest_flatted_in  input  NUM_REQUEST  destination mask; bit i targets port i; more than one bit set is multicast.
- request_valid_in  input  1  incoming request valid.
- issue_ack_out  output  1  request accepted this cycle (combinational).
- request_flatted_out  output  SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST  per-port head payload; port i occupies slice [i*W +: W].
- request_valid_flatted_out  output  NUM_REQUEST  per-port valid (queue non-empty).
- issue_ack_flatted_in  input  NUM_REQUEST  per-port consumer ack.
- queue_full_flatted_out  output  NUM_REQUEST  per-port queue full.
- drop_count_out  output  DROP_COUNT_WIDTH  count of requests dropped because of a zero destination mask.

Behaviour:
- Clock/reset: one clock (clk_in); reset is synchronous and active-high (reset_in).
- Transfer rule: a transfer happens on any edge where valid and ack are both high, on both the input and the output sides.
- Acceptance:
  - issue_ack_out = request_valid_in & no targeted queue full.
  - Fullness is evaluated from the registered occupancy before any same-cycle pop; there is no full-queue bypass.
- All-or-nothing multicast: if any targeted queue is full, the request is not acked and no queue is written. The producer must hold request_in and request_dest_flatted_in stable until acked.
- Push: on input transfer, the payload is written to the tail of every targeted queue on the same edge.
- Latency: 1 cycle. Data pushed at edge k is presented at the output after edge k if the queue was empty. There is no combinational fall-through.
- Output side:
  - request_valid_flatted_out[i] = occupancy_i != 0.
  - request_flatted_out slice i = head entry when valid, all-zero when empty.
- Pop: on edge with request_valid_flatted_out[i] & issue_ack_flatted_in[i], the head advances. Ack while valid is low is ignored, with no underflow.
- Simultaneous push and pop on the same non-full queue: occupancy unchanged, pointers both advance. On a 1-entry queue the popped head is replaced by the new entry next cycle.
- Pointers: read/write pointers are log2(OUTPUT_QUEUE_SIZE) bits and wrap naturally. Occupancy is log2+1 bits, 0..OUTPUT_QUEUE_SIZE. queue_full = occupancy == OUTPUT_QUEUE_SIZE.
- Zero mask: a valid request with dest == 0 is acked in the same cycle, stored nowhere, and drop_count_out increments by 1, saturating at all-ones.
- Port independence: ports are fully independent; a full port i blocks only requests that target port i.
- Reset:
  - All queues are emptied, pointers and occupancy go to 0, drop_count_out goes to 0.
  - request_valid_flatted_out = 0, request_flatted_out = 0, queue_full_flatted_out = 0.
  - issue_ack_out is 0 while reset_in is high.
  - Reset mid-operation discards all stored entries; a request presented during reset is not accepted.

Decomposition:
- Shared package/header: queue pointer-width calculation (clog2 of OUTPUT_QUEUE_SIZE) and slice-index helper constants, shared with the arbiter.
- One sub-module: distributor_output_queue, a single-port FIFO with push, pop, full, empty, head data and the zero-when-empty rule.
- Top level: generate-instantiates NUM_REQUEST copies of distributor_output_queue, plus the acceptance logic and the drop counter.

Test Plan (NUM_REQUEST=3, W=64, OUTPUT_QUEUE_SIZE=2):
- Unicast: send 0xA to dest 3'b010 with consumers acking.
  - Required: issue_ack_out=1 that cycle; next cycle port1 valid=1 with data 0xA; ports 0 and 2 remain invalid.
- Backpressure: port0 ack held low; send 0x1, 0x2, 0x3 to dest 3'b001.
  - Required: first two acked, queue_full[0]=1, third held unacked.
  - Then raise ack: outputs 0x1 then 0x2; 0x3 is acked the cycle after the first pop and emerges third.
- Multicast blocking: fill port2; send 0xB to dest 3'b111.
  - Required: no ack and ports 0 and 1 receive nothing.
  - Drain one entry from port2: the next cycle 0xB is acked and appears on all three ports.
- Simultaneous push/pop: port0 holds 1 entry and is acked every cycle while a stream 0x10..0x13 targets it.
  - Required: occupancy stays 1 and outputs appear in order with no gaps.
- Drop counter: 5 valid requests with dest=0.
  - Required: each is acked immediately, drop_count_out=5, all port valids stay 0.
  - Separately, force the counter to all-ones: it holds.
- Mid-operation reset: reset_in pulsed for 1 cycle with entries in all queues.
  - Required: the cycle after, all valids are 0, data is 0, drop_count_out=0, and a request presented during reset is not acked.
